// File: rtl/sigma_feeder.sv
// sigma_feeder: serial-to-parallel front end for the sigma bound unit.
// Collects ten 32-bit words (A00..A22 row-major, then err), fires a one-cycle
// tvalid at sigma, waits for its valid (or a timeout) and returns the bound
// on a ready/valid result port. Only one transaction is ever outstanding,
// because sigma has no backpressure and its internal delay line is only
// held while tvalid is low.
//
// Ports:
//   clk, reset_n              clock, async active-low reset
//   s_valid/s_ready/s_data    serial word input
//   tvalid, A00..A22, err     parallel issue to sigma
//   valid, sigma              result from sigma
//   m_valid/m_ready/m_data    result output; m_error=1 marks a timeout
//   stray                     sticky flag: sigma valid seen outside WAIT
module sigma_feeder #(
  parameter int PRECISION = 32,
  parameter int TIMEOUT   = 128,
  parameter int ABS_EN    = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [PRECISION-1:0] s_data,
  output logic                 tvalid,
  output logic [PRECISION-1:0] A00,
  output logic [PRECISION-1:0] A01,
  output logic [PRECISION-1:0] A02,
  output logic [PRECISION-1:0] A10,
  output logic [PRECISION-1:0] A11,
  output logic [PRECISION-1:0] A12,
  output logic [PRECISION-1:0] A20,
  output logic [PRECISION-1:0] A21,
  output logic [PRECISION-1:0] A22,
  output logic [PRECISION-1:0] err,
  input  logic                 valid,
  input  logic [PRECISION-1:0] sigma,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [PRECISION-1:0] m_data,
  output logic                 m_error,
  output logic                 stray
);

  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {LOAD, ISSUE, WAIT, HOLD} state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [WW-1:0]          wcnt_q, wcnt_d;
  logic [PRECISION-1:0]   m_data_q, m_data_d;
  logic                   m_error_q, m_error_d;
  logic                   stray_q;
  logic [PRECISION-1:0]   slot_q [0:9];
  logic [PRECISION-1:0]   load_w;
  logic                   accept;

  assign s_ready = (state_q == LOAD);
  assign tvalid  = (state_q == ISSUE);
  assign m_valid = (state_q == HOLD);
  assign accept  = s_valid && s_ready;

  // Matrix slots drop their sign so sigma sees |A|; err (slot 9) is untouched.
  always_comb begin
    load_w = s_data;
    if (ABS_EN != 0 && cnt_q != 4'd9) load_w[PRECISION-1] = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wcnt_d    = wcnt_q;
    m_data_d  = m_data_q;
    m_error_d = m_error_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (cnt_q == 4'd9) begin
            cnt_d   = 4'd0;
            state_d = ISSUE;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      ISSUE: begin
        wcnt_d  = '0;
        state_d = WAIT;
      end
      WAIT: begin
        wcnt_d = wcnt_q + 1'b1;
        // A valid on the timeout cycle still delivers the real result.
        if (valid) begin
          m_data_d  = sigma;
          m_error_d = 1'b0;
          state_d   = HOLD;
        end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
          m_data_d  = '0;
          m_error_d = 1'b1;
          state_d   = HOLD;
        end
      end
      HOLD: begin
        if (m_ready) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      m_data_q  <= '0;
      m_error_q <= 1'b0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      m_data_q  <= m_data_d;
      m_error_q <= m_error_d;
      if (valid && state_q != WAIT) stray_q <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 10; i++) slot_q[i] <= '0;
    end else if (accept) begin
      slot_q[cnt_q] <= load_w;
    end
  end

  assign A00     = slot_q[0];
  assign A01     = slot_q[1];
  assign A02     = slot_q[2];
  assign A10     = slot_q[3];
  assign A11     = slot_q[4];
  assign A12     = slot_q[5];
  assign A20     = slot_q[6];
  assign A21     = slot_q[7];
  assign A22     = slot_q[8];
  assign err     = slot_q[9];
  assign m_data  = m_data_q;
  assign m_error = m_error_q;
  assign stray   = stray_q;

endmodule

// File: tb/tb_sigma_feeder.sv
// Scoreboard bench for sigma_feeder: stimulus pushes expected issue vectors
// and results; two monitors pop and compare on tvalid and on the m handshake.
module tb_sigma_feeder;
  logic        clk = 1'b0;
  logic        reset_n, s_valid, s_ready, tvalid, valid, m_valid, m_ready;
  logic        m_error, stray;
  logic [31:0] s_data, A00, A01, A02, A10, A11, A12, A20, A21, A22, err;
  logic [31:0] sigma, m_data;

  always #5 clk = ~clk;

  sigma_feeder dut (
    .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .tvalid(tvalid), .A00(A00), .A01(A01), .A02(A02),
    .A10(A10), .A11(A11), .A12(A12), .A20(A20), .A21(A21), .A22(A22),
    .err(err), .valid(valid), .sigma(sigma), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_error(m_error), .stray(stray)
  );

  typedef logic [9:0][31:0] vec_t;
  typedef struct packed { logic [31:0] d; logic e; } res_t;

  int   checks = 0, errors = 0, cyc = 0;
  vec_t exp_a_q[$];
  res_t exp_r_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Responder: one valid with 0x40400000 exactly 86 cycles after each tvalid.
  bit   resp_en = 1'b1;
  logic resp_v = 1'b0, man_v = 1'b0;
  int   due_q[$];
  assign valid = resp_v | man_v;
  assign sigma = 32'h40400000;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    resp_v <= 1'b0;
    if (tvalid && resp_en) due_q.push_back(cyc + 86);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      resp_v <= 1'b1;
      void'(due_q.pop_front());
    end
  end

  // Issue monitor
  always @(negedge clk) begin
    vec_t act, exp;
    #1;
    if (tvalid) begin
      act = {err, A22, A21, A20, A12, A11, A10, A02, A01, A00};
      if (exp_a_q.size() == 0) chk("tvalid_unexpected", 32'd1, 32'd0);
      else begin
        exp = exp_a_q.pop_front();
        for (int i = 0; i < 10; i++) chk($sformatf("issue_slot%0d", i), act[i], exp[i]);
      end
    end
  end

  // Result monitor
  always @(negedge clk) begin
    res_t r;
    #1;
    if (m_valid && m_ready) begin
      if (exp_r_q.size() == 0) chk("result_unexpected", 32'd1, 32'd0);
      else begin
        r = exp_r_q.pop_front();
        chk("m_data", m_data, r.d);
        chk("m_error", {31'd0, m_error}, {31'd0, r.e});
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int g = 0;
    @(negedge clk);
    while (!s_ready && g < 1000) begin
      s_valid = 1'b0;
      @(negedge clk);
      g++;
    end
    if (g >= 1000) chk("s_ready_timeout", 32'd0, 32'd1);
    s_valid = 1'b1;
    s_data  = w;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_valid = 1'b0;
    end
  endtask

  // Streams ten words and checks the single-cycle tvalid that follows.
  task automatic send_txn(input vec_t w, input bit gaps);
    for (int i = 0; i < 10; i++) begin
      if (gaps) idle($urandom_range(0, 3));
      send_word(w[i]);
    end
    @(negedge clk);
    s_valid = 1'b0;
    #1 chk("tvalid_pulse", {31'd0, tvalid}, 32'd1);
    @(negedge clk);
    #1 chk("tvalid_one_cycle", {31'd0, tvalid}, 32'd0);
  endtask

  task automatic wait_mvalid();
    int g = 0;
    while (!m_valid && g < 400) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 400) chk("m_valid_timeout", 32'd0, 32'd1);
  endtask

  vec_t v, e;
  bit   bad;

  initial begin
    reset_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_error", {31'd0, m_error}, 32'd0);
    chk("rst_stray", {31'd0, stray}, 32'd0);
    chk("rst_m_data", m_data, 32'd0);
    chk("rst_A00", A00, 32'd0);
    chk("rst_err", err, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1 chk("s_ready_after_reset", {31'd0, s_ready}, 32'd1);

    // Identity, no gaps
    v = '0;
    v[0] = 32'h3F800000; v[4] = 32'h3F800000; v[8] = 32'h3F800000;
    exp_a_q.push_back(v);
    exp_r_q.push_back('{d: 32'h40400000, e: 1'b0});
    send_txn(v, 1'b0);
    wait_mvalid();
    idle(2);

    // Negative elements with gaps: sign stripped except on err
    for (int i = 0; i < 9; i++) begin v[i] = 32'hBF800000; e[i] = 32'h3F800000; end
    v[9] = 32'hBF000000; e[9] = 32'hBF000000;
    exp_a_q.push_back(e);
    exp_r_q.push_back('{d: 32'h40400000, e: 1'b0});
    send_txn(v, 1'b1);
    wait_mvalid();
    idle(2);

    // Backpressure for 20 cycles, then a back-to-back transaction
    m_ready = 1'b0;
    for (int i = 0; i < 9; i++) v[i] = 32'h40000000;
    v[9] = 32'h3F000000;
    exp_a_q.push_back(v);
    exp_r_q.push_back('{d: 32'h40400000, e: 1'b0});
    send_txn(v, 1'b0);
    wait_mvalid();
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      #1;
      if (m_valid !== 1'b1 || m_data !== 32'h40400000 || m_error !== 1'b0 || s_ready !== 1'b0)
        bad = 1'b1;
    end
    chk("hold_stable", {31'd0, bad}, 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("s_ready_after_handshake", {31'd0, s_ready}, 32'd1);
    chk("m_valid_after_handshake", {31'd0, m_valid}, 32'd0);
    for (int i = 0; i < 10; i++) v[i] = 32'h00000100 + i;
    exp_a_q.push_back(v);
    exp_r_q.push_back('{d: 32'h40400000, e: 1'b0});
    send_txn(v, 1'b0);
    wait_mvalid();
    idle(2);

    // Timeout with a silent responder, then a late valid sets stray
    resp_en = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 10; i++) v[i] = 32'h3E000000;
    exp_a_q.push_back(v);
    exp_r_q.push_back('{d: 32'h0, e: 1'b1});
    send_txn(v, 1'b0);
    repeat (127) @(negedge clk);
    #1 chk("timeout_not_early", {31'd0, m_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("timeout_m_valid", {31'd0, m_valid}, 32'd1);
    chk("timeout_m_error", {31'd0, m_error}, 32'd1);
    chk("timeout_m_data", m_data, 32'd0);
    chk("stray_before_late", {31'd0, stray}, 32'd0);
    @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    man_v = 1'b1;
    @(negedge clk);
    man_v = 1'b0;
    #1 chk("stray_late_valid", {31'd0, stray}, 32'd1);
    resp_en = 1'b1;
    idle(2);

    // Reset during WAIT, old valid lands in LOAD, new transaction completes
    for (int i = 0; i < 10; i++) v[i] = 32'h3F000000;
    exp_a_q.push_back(v);
    send_txn(v, 1'b0);
    repeat (38) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("wrst_tvalid", {31'd0, tvalid}, 32'd0);
    chk("wrst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("wrst_m_error", {31'd0, m_error}, 32'd0);
    chk("wrst_stray", {31'd0, stray}, 32'd0);
    chk("wrst_A00", A00, 32'd0);
    chk("wrst_A22", A22, 32'd0);
    chk("wrst_err", err, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(60);
    #1 chk("stray_old_valid", {31'd0, stray}, 32'd1);
    v = '0;
    v[1] = 32'h3F800000; v[9] = 32'h3A000000;
    exp_a_q.push_back(v);
    exp_r_q.push_back('{d: 32'h40400000, e: 1'b0});
    send_txn(v, 1'b0);
    wait_mvalid();
    idle(3);

    chk("issue_queue_drained", exp_a_q.size(), 32'd0);
    chk("result_queue_drained", exp_r_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sigma_feeder.md
# sigma_feeder

Front-end initiator for the `sigma` floating-point bound unit. It accepts a serial stream of ten IEEE-754 single-precision words: the nine 3x3 matrix elements in row-major order, then `err`. It presents them in parallel to `sigma` with a single-cycle `tvalid` pulse and waits for the unit's `valid`. The returned bound goes out on a ready/valid result port. The block keeps exactly one transaction outstanding. This is required because `sigma` holds its column-2 delay line only while `tvalid` is low and has no backpressure.

## Interface
- `PRECISION`, 32, word width; only 32 supported.
- `TIMEOUT`, 128, number of WAIT cycles allowed for `sigma` `valid` before the transaction is aborted. Must be at least 2 and greater than the `sigma` latency (~86 cycles).
- `ABS_EN`, 1, when 1 clear bit 31 of each matrix element on load, so `sigma` computes a true infinity norm; `err` is never modified.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous active-low reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word ready.
- `s_data`  in  PRECISION  input word.
- `tvalid`  out  1  one-cycle issue pulse to `sigma`.
- `A00`..`A22`  out  PRECISION each  matrix elements to `sigma` (nine ports).
- `err`  out  PRECISION  error term to `sigma`.
- `valid`  in  1  result valid from `sigma`.
- `sigma`  in  PRECISION  result from `sigma`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result ready.
- `m_data`  out  PRECISION  captured sigma; 0 on timeout.
- `m_error`  out  1  qualifies `m_data`; 1 means timeout.
- `stray`  out  1  sticky; set when `valid` arrives outside WAIT; cleared only by reset.

## Operation
- Reset values: state LOAD; word counter 0; `tvalid`, `m_valid`, `m_error`, `stray` are 0; `m_data`, `A00`..`A22` and `err` are 0. `s_ready` is 1 from the first cycle after reset release.
- FSM states are LOAD, ISSUE, WAIT and HOLD.
- LOAD:
  - `s_ready` = 1, decoded from the state register.
  - Each accepted word (`s_valid && s_ready`) is written to slot `cnt`: 0→`A00`, 1→`A01`, 2→`A02`, 3→`A10`, … 8→`A22`, 9→`err`.
  - With `ABS_EN`, slots 0–8 store `{1'b0, s_data[30:0]}`.
  - `cnt` increments on each accept. Gaps in `s_valid` are allowed.
  - On the accept with `cnt`==9: `cnt`←0 and go to ISSUE.
- ISSUE: `tvalid`=1 for exactly this one cycle; `s_ready`=0. Go to WAIT.
- WAIT:
  - Wait counter starts at 0 and increments each cycle.
  - If `valid`=1: `m_data`←`sigma`, `m_error`←0, go to HOLD.
  - Otherwise, if counter == TIMEOUT-1: `m_data`←0, `m_error`←1, go to HOLD.
  - If `valid` and the timeout coincide, `valid` wins.
- HOLD:
  - `m_valid`=1. `m_data` and `m_error` stay stable until `m_valid && m_ready`; then go to LOAD.
  - `s_ready` stays 0 until the state is LOAD.
- `A00`..`A22` and `err` change only on LOAD accepts. They are stable throughout ISSUE and WAIT.
- `valid` in LOAD, ISSUE or HOLD is dropped and sets `stray`. `m_data` is not touched.
- Reset asserted in any state returns all registers to reset values immediately. A partial load is discarded.

## Timing
- Accept of the 10th word at edge k: `tvalid` is high for the cycle between edges k and k+1.
- WAIT begins at edge k+1.
- `valid` sampled high at edge j: `m_valid` is high from edge j onward.
- Timeout: `m_valid` and `m_error` rise at edge k+1+TIMEOUT.
- Handshake at edge h: `s_ready` is high after edge h, so the next word can be accepted at edge h+1.
- Minimum load time is 10 cycles. Throughput: at most one transaction per 10 + 1 + sigma latency + 1 cycles.

## Test plan
- Bench responder model: returns `valid` with a fixed 0x40400000 exactly 86 cycles after `tvalid`.
- Identity matrix, `err`=0x00000000, streamed with no gaps:
  - One-cycle `tvalid` the cycle after the 10th accept.
  - `A00`/`A11`/`A22` = 0x3F800000, all other elements 0.
  - `m_data`=0x40400000 with `m_error`=0.
- Elements 0xBF800000, random `s_valid` gaps, `ABS_EN`=1: all `A` ports show 0x3F800000; `err` keeps 0xBF000000 unmodified.
- Responder silent, `TIMEOUT`=128: `m_valid`=1, `m_error`=1, `m_data`=0 exactly 128 cycles after WAIT entry. A late `valid` after that sets `stray`=1.
- Hold `m_ready` low for 20 cycles after the result:
  - `m_valid`, `m_data` and `s_ready`=0 stay stable the whole time.
  - After the handshake, `s_ready`=1 on the next cycle.
  - A second back-to-back transaction produces a correct result.
- Assert `reset_n` low for one cycle at WAIT cycle 40, then re-stream:
  - All outputs are at reset values during reset.
  - The old responder `valid` sets `stray`.
  - The new transaction completes normally.
